// File: rtl/pcihellocore_pio_arbiter.sv
// Two-requester arbiter in front of the PIO Avalon-MM slave: host (m0) preferred,
// local sequencer (m1) protected from starvation by a saturating burst counter.
module pcihellocore_pio_arbiter #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic [1:0]  m0_address,
    input  logic        m0_chipselect,
    input  logic        m0_write_n,
    input  logic        m0_read_n,
    input  logic [31:0] m0_writedata,
    output logic        m0_waitrequest,
    output logic [31:0] m0_readdata,
    output logic        m0_readdatavalid,

    input  logic [1:0]  m1_address,
    input  logic        m1_chipselect,
    input  logic        m1_write_n,
    input  logic        m1_read_n,
    input  logic [31:0] m1_writedata,
    output logic        m1_waitrequest,
    output logic [31:0] m1_readdata,
    output logic        m1_readdatavalid,

    output logic [1:0]  pio_address,
    output logic        pio_chipselect,
    output logic        pio_write_n,
    output logic [31:0] pio_writedata,
    input  logic [31:0] pio_readdata
);

    localparam int unsigned AW = 2;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 4;

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t        state, state_nx;
    logic          grant, grant_nx;
    logic [CW-1:0] starve_cnt, starve_nx;
    logic [AW-1:0] pio_address_nx;
    logic [DW-1:0] pio_writedata_nx;
    logic          pio_write_n_nx, pio_chipselect_nx;
    logic          m0_waitrequest_nx, m1_waitrequest_nx;
    logic [DW-1:0] m0_readdata_nx, m1_readdata_nx;
    logic          m0_readdatavalid_nx, m1_readdatavalid_nx;
    logic          req0_c, req1_c, win1_c;

    assign req0_c = m0_chipselect & (~m0_write_n | ~m0_read_n);
    assign req1_c = m1_chipselect & (~m1_write_n | ~m1_read_n);

    // Next-state, arbitration and next-output logic
    always_comb begin
        state_nx            = state;
        grant_nx            = grant;
        starve_nx           = starve_cnt;
        pio_address_nx      = pio_address;
        pio_writedata_nx    = pio_writedata;
        pio_write_n_nx      = 1'b1;
        pio_chipselect_nx   = 1'b0;
        m0_waitrequest_nx   = 1'b1;
        m1_waitrequest_nx   = 1'b1;
        m0_readdata_nx      = m0_readdata;
        m1_readdata_nx      = m1_readdata;
        m0_readdatavalid_nx = 1'b0;
        m1_readdatavalid_nx = 1'b0;
        win1_c              = 1'b0;

        case (state)
            IDLE: begin
                if (req0_c | req1_c) begin
                    win1_c            = req1_c & (~req0_c | (starve_cnt == CW'(MAX_BURST)));
                    grant_nx          = win1_c;
                    state_nx          = ISSUE;
                    pio_chipselect_nx = 1'b1;
                    if (win1_c) begin
                        pio_address_nx    = m1_address;
                        pio_writedata_nx  = m1_writedata;
                        pio_write_n_nx    = m1_write_n;
                        m1_waitrequest_nx = 1'b0;
                        starve_nx         = '0;
                    end else begin
                        pio_address_nx    = m0_address;
                        pio_writedata_nx  = m0_writedata;
                        pio_write_n_nx    = m0_write_n;
                        m0_waitrequest_nx = 1'b0;
                        // count host grants only while m1 is actually waiting
                        if (!req1_c)
                            starve_nx = '0;
                        else if (starve_cnt != CW'(MAX_BURST))
                            starve_nx = starve_cnt + CW'(1);
                    end
                end
            end
            ISSUE: begin
                state_nx = IDLE;
                // pio_write_n high during ISSUE marks a read; capture the PIO's data
                if (pio_write_n) begin
                    if (grant) begin
                        m1_readdata_nx      = pio_readdata;
                        m1_readdatavalid_nx = 1'b1;
                    end else begin
                        m0_readdata_nx      = pio_readdata;
                        m0_readdatavalid_nx = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state            <= IDLE;
            grant            <= 1'b0;
            starve_cnt       <= '0;
            pio_address      <= '0;
            pio_writedata    <= '0;
            pio_write_n      <= 1'b1;
            pio_chipselect   <= 1'b0;
            m0_waitrequest   <= 1'b1;
            m1_waitrequest   <= 1'b1;
            m0_readdata      <= '0;
            m1_readdata      <= '0;
            m0_readdatavalid <= 1'b0;
            m1_readdatavalid <= 1'b0;
        end else begin
            state            <= state_nx;
            grant            <= grant_nx;
            starve_cnt       <= starve_nx;
            pio_address      <= pio_address_nx;
            pio_writedata    <= pio_writedata_nx;
            pio_write_n      <= pio_write_n_nx;
            pio_chipselect   <= pio_chipselect_nx;
            m0_waitrequest   <= m0_waitrequest_nx;
            m1_waitrequest   <= m1_waitrequest_nx;
            m0_readdata      <= m0_readdata_nx;
            m1_readdata      <= m1_readdata_nx;
            m0_readdatavalid <= m0_readdatavalid_nx;
            m1_readdatavalid <= m1_readdatavalid_nx;
        end
    end

endmodule

// File: doc/pcihellocore_pio_arbiter.md
Name: pcihellocore_pio_arbiter

Overview:
Shares the PIO's Avalon-MM slave port between two requesters: the PCIe host bridge (m0, preferred) and a local sequencer (m1).
Serialises single-beat reads and writes onto the PIO bus.
Bounds host-induced starvation of m1 with a burst counter.
Sits between the interconnect and the PIO instance; the PIO's out_port drives the DE2i-150 seven-segment displays.

Parameters:
MAX_BURST, 4, consecutive host grants allowed while m1 waits; legal range 1..15.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
m0_address  in  2  host word address
m0_chipselect  in  1  host select
m0_write_n  in  1  host write strobe, active-low
m0_read_n  in  1  host read strobe, active-low
m0_writedata  in  32  host write data
m0_waitrequest  out  1  host stall
m0_readdata  out  32  host read data, registered
m0_readdatavalid  out  1  host read data valid pulse
m1_address, m1_chipselect, m1_write_n, m1_read_n, m1_writedata, m1_waitrequest, m1_readdata, m1_readdatavalid: same widths and meanings for the local requester
pio_address  out  2  to PIO address
pio_chipselect  out  1  to PIO chipselect
pio_write_n  out  1  to PIO write_n
pio_writedata  out  32  to PIO writedata
pio_readdata  in  32  from PIO readdata; combinational in the PIO

Behaviour:
- Interface: one clock (clk); reset_n is asynchronous, active-low.
- reqN = mN_chipselect & (~mN_write_n | ~mN_read_n).
- If both strobes are low, the access is a write; the read is ignored and no readdatavalid is generated.
- Masters hold address, data and strobes stable while waitrequest=1.
- FSM states: IDLE, ISSUE.
- IDLE:
  - If any reqN, select a winner, register its address, writedata and write_n into pio_*, set grant, and go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE:
  - pio_chipselect=1 for exactly this one cycle.
  - Winner's waitrequest=0 in this cycle only; this is the accept cycle.
  - For a read, capture pio_readdata into mN_readdata at the clock edge ending ISSUE.
  - Always return to IDLE.
- Latency:
  - Request seen in IDLE at cycle t -> accept (waitrequest low) at t+1.
  - Read data valid at t+2.
  - Maximum throughput is one access per 2 cycles.
- mN_waitrequest = ~(state==ISSUE & grant==N). It is high whenever the port is not being accepted, including when idle.
- pio_write_n = 1 except during a write's ISSUE cycle.
- pio_address and pio_writedata hold their last value outside ISSUE.
- mN_readdatavalid: a 1-cycle pulse in the cycle after a read's ISSUE. mN_readdata holds its value until that port's next read.
- Arbitration:
  - Only req1 -> m1; only req0 -> m0.
  - Both requesting -> m0, unless starve_cnt==MAX_BURST, in which case m1.
- starve_cnt (4 bits) is updated at each grant:
  - Increments on an m0 grant while req1=1.
  - Cleared on any m1 grant.
  - Cleared on an m0 grant with req1=0.
  - Saturates at MAX_BURST.
- Requests are sampled only in IDLE; a request arriving during ISSUE waits one cycle.
- Same master re-requesting immediately after accept: seen in the following IDLE cycle, with normal arbitration.
- Reset values:
  - state=IDLE; grant=0; starve_cnt=0.
  - pio_chipselect=0, pio_write_n=1, pio_address=0, pio_writedata=0.
  - mN_waitrequest=1, mN_readdata=0, mN_readdatavalid=0.
- Reset asserted mid-ISSUE:
  - pio_chipselect drops immediately (asynchronous).
  - The access is treated as not performed from the arbiter's view.
  - No readdatavalid after reset release.

Test Plan:
1. Reset: hold reset_n=0 -> m0/m1_waitrequest=1, pio_chipselect=0, pio_write_n=1, readdata=0, readdatavalid=0; release -> FSM in IDLE, no PIO traffic.
2. m0 writes addr 0, data 0x12345678 at cycle t -> at t+1 pio_chipselect=1, pio_write_n=0, pio_address=0, pio_writedata=0x12345678, m0_waitrequest=0; at t+2 pio_chipselect=0, m0_waitrequest=1.
3. m1 reads addr 0, PIO returning 0x40404040 -> m1_waitrequest=0 at t+1; m1_readdatavalid=1 with m1_readdata=0x40404040 at t+2 only; m0_readdatavalid stays 0.
4. Both continuously request writes, MAX_BURST=4 -> grant order m0,m0,m0,m0,m1,m0,m0,m0,m0,m1; one pio_chipselect pulse every 2 cycles.
5. m0 asserts write_n=0 and read_n=0 with data 0xA5A5A5A5 -> single PIO write of 0xA5A5A5A5; no m0_readdatavalid.
6. m1 read in progress; reset_n pulled low during ISSUE -> pio_chipselect=0 in the same cycle; after release no m1_readdatavalid, m1_readdata=0, state IDLE.
